// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches one instruction at a time,
// hands it to decode and advances the PC on commit. Faults are sticky until reset.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    input  logic            commit,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault,
    output logic            fault_misalign,
    output logic [XLEN-1:0] fault_addr,
    output logic [63:0]     instret
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        EXEC  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic rsp_taken;
    logic commit_taken;
    logic target_aligned;

    assign rsp_taken      = (state == WAIT) && imem_rsp_valid;
    assign commit_taken   = (state == EXEC) && commit;
    assign target_aligned = (pc_next[1:0] == 2'b00);
    assign imem_addr      = pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
    always_comb begin
        next_state     = state;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state)
            BOOT: begin
                next_state = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    next_state = imem_rsp_err ? FAULT : ISSUE;
                end
            end
            ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    next_state = target_aligned ? REQ : FAULT;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc             <= RESET_PC;
            inst           <= '0;
            inst_pc        <= '0;
            fault          <= 1'b0;
            fault_misalign <= 1'b0;
            fault_addr     <= '0;
            instret        <= '0;
        end else begin
            if (rsp_taken) begin
                if (imem_rsp_err) begin
                    fault          <= 1'b1;
                    fault_misalign <= 1'b0;
                    fault_addr     <= pc;
                end else begin
                    inst    <= imem_rsp_data;
                    inst_pc <= pc;
                end
            end
            // A misaligned target still retires the instruction, but the PC is left alone.
            if (commit_taken) begin
                instret <= instret + 64'd1;
                if (target_aligned) begin
                    pc <= pc_next;
                end else begin
                    fault          <= 1'b1;
                    fault_misalign <= 1'b1;
                    fault_addr     <= pc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized self-checking bench for fetch_ctrl: the bench acts as instruction memory
// and decode, and tracks PC/instret/fault with a transaction-level model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_next = '0;
    logic        commit = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic        fault_misalign;
    logic [31:0] fault_addr;
    logic [63:0] instret;

    int total = 0;
    int bad = 0;

    logic [31:0] m_pc;
    logic [63:0] m_instret;
    logic        m_fault;
    logic        m_mis;
    logic [31:0] m_faddr;

    fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pc            (pc),
        .pc_next       (pc_next),
        .commit        (commit),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .fault         (fault),
        .fault_misalign(fault_misalign),
        .fault_addr    (fault_addr),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] memData(input logic [31:0] addr);
        if (addr == 32'h100) return 32'h0000_0013;
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkFaultState(input string tag);
        checkOutput({tag, "_fault"}, fault, m_fault);
        checkOutput({tag, "_mis"}, fault_misalign, m_mis);
        checkOutput({tag, "_faddr"}, fault_addr, m_faddr);
        checkOutput({tag, "_pc"}, pc, m_pc);
        checkOutput({tag, "_instret"}, instret, m_instret);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        commit = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        inst_ready = 1'b0;
        m_pc = RST_PC;
        m_instret = '0;
        m_fault = 1'b0;
        m_mis = 1'b0;
        m_faddr = '0;
        repeat (3) tick();
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_addr", imem_addr, RST_PC);
        checkOutput("rst_req", imem_req_valid, 0);
        checkOutput("rst_ivalid", inst_valid, 0);
        checkOutput("rst_inst", inst, 0);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkFaultState("rst");
        rstn = 1'b1;
        #1;
        checkOutput("boot_req", imem_req_valid, 0);
        tick();
        checkOutput("first_req", imem_req_valid, 1);
        checkOutput("first_addr", imem_addr, RST_PC);
    endtask

    // One full fetch/issue/commit round; delays are in cycles, lat >= 1.
    task automatic applyStimulus(input logic [31:0] npc, input int req_dly, input int lat,
                                 input int bp, input int cdly, input bit err);
        int guard;
        logic [31:0] data;
        guard = 0;
        while (!imem_req_valid && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("req_seen", imem_req_valid, 1);
        if (!imem_req_valid) return;
        checkOutput("req_addr", imem_addr, m_pc);
        for (int i = 0; i < req_dly; i++) begin
            tick();
            checkOutput("req_hold", {imem_req_valid, imem_addr}, {1'b1, m_pc});
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        data = memData(m_pc);
        for (int i = 0; i < lat - 1; i++) begin
            checkOutput("wait_idle", {imem_req_valid, inst_valid}, 0);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data = data;
        imem_rsp_err = err;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        imem_rsp_data = $urandom;
        if (err) begin
            m_fault = 1'b1;
            m_mis = 1'b0;
            m_faddr = m_pc;
            checkFaultState("acc");
            checkOutput("acc_ivalid", inst_valid, 0);
            return;
        end
        checkOutput("issue_valid", inst_valid, 1);
        checkOutput("issue_inst", inst, data);
        checkOutput("issue_pc", inst_pc, m_pc);
        for (int i = 0; i < bp; i++) begin
            commit = 1'($urandom_range(0, 1));
            pc_next = $urandom;
            tick();
            commit = 1'b0;
            checkOutput("bp_hold", {inst_valid, imem_req_valid, inst}, {1'b1, 1'b0, data});
            checkOutput("bp_inst_pc", inst_pc, m_pc);
            checkOutput("bp_pc", pc, m_pc);
            checkOutput("bp_instret", instret, m_instret);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checkOutput("exec_ivalid", {inst_valid, imem_req_valid}, 0);
        for (int i = 0; i < cdly; i++) begin
            tick();
            checkOutput("exec_pc", pc, m_pc);
        end
        commit = 1'b1;
        pc_next = npc;
        tick();
        commit = 1'b0;
        pc_next = $urandom;
        m_instret = m_instret + 64'd1;
        if (npc[1:0] == 2'b00) begin
            m_pc = npc;
            checkOutput("commit_pc", pc, m_pc);
            checkOutput("commit_instret", instret, m_instret);
            checkOutput("redirect_req", {imem_req_valid, imem_addr}, {1'b1, npc});
        end else begin
            m_fault = 1'b1;
            m_mis = 1'b1;
            m_faddr = npc;
            checkFaultState("mis");
        end
    endtask

    task automatic checkQuiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            commit = 1'($urandom_range(0, 1));
            pc_next = {$urandom_range(0, 16'hFFFF), 2'b00};
            tick();
            checkOutput("quiet_out", {imem_req_valid, inst_valid}, 0);
            checkFaultState("quiet");
        end
        imem_req_ready = 1'b0;
        commit = 1'b0;
    endtask

    initial begin
        #1;
        doReset();

        // straight-line, backpressure with spurious commits, branch redirect
        applyStimulus(32'h104, 0, 1, 0, 0, 1'b0);
        applyStimulus(32'h200, 1, 2, 5, 1, 1'b0);
        applyStimulus(32'h080, 0, 1, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus({14'd0, 16'($urandom_range(0, 16'hFFFF)), 2'b00},
                          $urandom_range(0, 3), $urandom_range(1, 4),
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        // misaligned target
        doReset();
        applyStimulus(32'h102, 0, 1, 0, 0, 1'b0);
        checkQuiet(10);

        // access error at 0x300
        doReset();
        applyStimulus(32'h300, 0, 2, 0, 0, 1'b0);
        applyStimulus(32'h0, 0, 1, 0, 0, 1'b1);
        checkQuiet(10);

        // reset while waiting for a response, then a stale response during BOOT/REQ
        doReset();
        applyStimulus(32'h240, 0, 1, 1, 0, 1'b0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_pc", pc, RST_PC);
        checkOutput("mid_rst_instret", instret, 0);
        checkOutput("mid_rst_out", {imem_req_valid, inst_valid}, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        checkOutput("stale_inst", inst, 0);
        checkOutput("stale_state", {imem_req_valid, inst_valid}, {1'b1, 1'b0});
        imem_rsp_valid = 1'b0;
        m_pc = RST_PC;
        m_instret = '0;
        m_fault = 1'b0;
        m_mis = 1'b0;
        m_faddr = '0;
        applyStimulus(32'h104, 0, 3, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
